des_round_f_pipe: RTL and testbench
===================================

Name: des_round_f_pipe

Overview:
- Pipelined DES round function: f(R, K) = P(S(E(R) xor K)).
- Sits between the key-schedule/round controller (supplies R and 48-bit subkey) and the L-xor stage. Consumes the existing S-box modules.
- Instantiates the team's sbox1..sbox8 leaf blocks combinationally; each takes a 6-bit input and returns a 4-bit output, with row = {b5,b0} and col = b4:1.
- Two-stage valid/ready pipeline with a sideband tag, so the round controller can keep several blocks in flight.

Parameters:
- TAG_W, 4, width of opaque tag carried alongside each operation (block/round id); returned unchanged.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation present
- in_ready  out  1  block can accept input this cycle
- in_r  in  32  right half R, bit 31 = DES bit 1
- in_k  in  48  round subkey, bit 47 = DES bit 1
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_f  out  32  f(R,K), bit 31 = DES bit 1
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Bit numbering: DES bit n maps to vector bit (W-n). E and P are the FIPS 46-3 tables.
- Stage 1 (capture): on input handshake (in_valid & in_ready), register x1 = E(in_r) xor in_k (48 b), tag1, and set v1 = 1.
- Stage 2 (output): x1 is split into eight 6-bit groups; x1[47:42] goes to sbox1 and x1[5:0] goes to sbox8. The 32-bit concatenation s = {s1..s8} is permuted by P. On stage advance, register out_f = P(s), out_tag = tag1, and set v2 = 1.
- Latency: 2 cycles from the input handshake to out_valid with no stall. Throughput is 1 operation per cycle.
- Flow control:
  - adv2 = v1 & (!v2 | out_ready)
  - in_ready = !v1 | adv2
  - v2 clears when out_ready & v2 & !adv2
  - v1 clears when adv2 & !(in_valid & in_ready)
  - in_ready is a combinational function of state and out_ready only; no path from in_valid.
- Stall:
  - while out_valid & !out_ready: out_f/out_tag are held stable.
  - v1 holds its data, and in_ready = 0 once both stages are full.
- Simultaneous events:
  - output consumed and new input accepted in the same cycle: both stages update and no bubble is inserted.
  - both stages full and out_ready = 1: v2 reloads from stage 1 and stage 1 reloads from input in one cycle.
- Reset (async, any time including mid-stall):
  - v1 = v2 = 0, out_valid = 0, out_f = 0, out_tag = 0, x1 = 0, tag1 = 0.
  - in_ready = 1 from the first cycle after deassertion.
  - In-flight operations are discarded, not replayed.
- No arithmetic beyond xor. Widths are exact; no truncation or extension.
- out_f/out_tag are don't-care to consumers when out_valid = 0 but must remain the last registered value.

Test Plan:
- Known vector: in_r=F0AAF0AA, in_k=1B02EFFC7072, out_ready=1 -> 2 cycles later out_valid=1, out_f=234AA9BB; internal x1=6117BA866527, S-output 5C82B597.
- Back-to-back: drive the vector above with tag=1, then in_r=00000000, in_k=000000000000, tag=2 on consecutive cycles -> results appear in consecutive cycles in order.
  - Tag 1: 234AA9BB.
  - Tag 2: P(EFA72C4D) against the golden model.
- Backpressure: out_ready=0 while issuing 3 inputs -> in_ready drops after 2 accepts and out_f is held. Releasing out_ready for 1 cycle each drains tags in order with no loss or duplication.
- Simultaneous push/pop with both stages full and out_ready=1 -> one result out and one input in on the same edge; occupancy unchanged.
- Reset mid-stall: assert rst_n=0 asynchronously between edges -> out_valid=0 and out_f=0 immediately. After release, in_ready=1 and stale tags never appear.
- Random regression: 10k random R/K/tag with random out_ready -> every out_f matches the reference DES f-model, and tag order is preserved.

Source files
------------

// File: rtl/des_round_f_pipe.sv
// des_round_f_pipe
//   Pipelined DES round function f(R,K) = P(S(E(R) xor K)).
//   Stage 1 registers E(R) xor K together with the sideband tag.
//   Stage 2 runs the eight S-boxes and P, then registers the result and tag.
//   Valid/ready on both sides; in_ready depends only on state and out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input operation present
//   in_ready   block can accept input this cycle
//   in_r       right half R   (bit 31 = DES bit 1)
//   in_k       round subkey   (bit 47 = DES bit 1)
//   in_tag     opaque tag, returned unchanged with the result
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_f      f(R,K)         (bit 31 = DES bit 1)
//   out_tag    tag belonging to out_f
module des_round_f_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_r,
    input  logic [47:0]      in_k,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_f,
    output logic [TAG_W-1:0] out_tag
);

    // E and P in DES bit numbering (1 = MSB); DES bit n sits at vector bit W-n.
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Contents of sbox1..sbox8. Each entry is 64 nibbles, entry
    // (row*16 + col) stored MSB-first, so entry 0 is bits [255:252].
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row is {b5,b0}, column is b4:1; {row,col} forms the entry index.
    function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] x);
        logic [5:0]   idx;
        logic [255:0] sh;
        idx = {x[5], x[0], x[4:1]};
        sh  = SBOX[n] << {idx, 2'b00};
        return sh[255:252];
    endfunction

    logic             v1, v2;
    logic [47:0]      x1;
    logic [TAG_W-1:0] tag1;
    logic             adv2, in_fire;
    logic [47:0]      e_r;
    logic [31:0]      s_cat, p_s;

    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = v2;

    always_comb begin
        e_r = '0;
        for (int i = 0; i < 48; i++) begin
            e_r[47-i] = in_r[32-E_TAB[i]];
        end
    end

    always_comb begin
        s_cat = '0;
        p_s   = '0;
        for (int j = 0; j < 8; j++) begin
            s_cat[31-4*j -: 4] = sbox_lookup(j, x1[47-6*j -: 6]);
        end
        for (int i = 0; i < 32; i++) begin
            p_s[31-i] = s_cat[32-P_TAB[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            x1   <= '0;
            tag1 <= '0;
        end else if (in_fire) begin
            v1   <= 1'b1;
            x1   <= e_r ^ in_k;
            tag1 <= in_tag;
        end else if (adv2) begin
            v1   <= 1'b0;
        end
    end

    // Output registers only move on advance, so they hold through stalls
    // and keep the last result after it has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            out_f   <= '0;
            out_tag <= '0;
        end else if (adv2) begin
            v2      <= 1'b1;
            out_f   <= p_s;
            out_tag <= tag1;
        end else if (out_ready) begin
            v2      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_round_f_pipe.sv
module tb_des_round_f_pipe;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_r;
    logic [47:0]      in_k;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic [TAG_W-1:0] out_tag;

    des_round_f_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_k      (in_k),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, written from the standard tables in a different form.
    localparam int SB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    localparam int PT [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                               2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        logic [5:0]  g;
        int          db, sv;
        x = '0; s = '0; p = '0;
        // E: group j takes DES bits 4j..4j+5 of R, wrapping 0->32 and 33->1.
        for (int j = 0; j < 8; j++) begin
            for (int m = 0; m < 6; m++) begin
                db = 4*j + m;
                if (db == 0) db = 32;
                if (db == 33) db = 1;
                x[47-(6*j+m)] = r[32-db];
            end
        end
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            g  = x[47-6*j -: 6];
            sv = SB[j][(g[5] ? 32 : 0) + (g[0] ? 16 : 0) + int'(g[4:1])];
            s[31-4*j -: 4] = 4'(sv);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-PT[i]];
        return p;
    endfunction

    typedef struct packed {
        logic [31:0]      f;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    logic hold_pending = 1'b0;
    logic [63:0] held;

    // Scoreboard: push on input handshake, pop on output handshake.
    // Sampled on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check("stall_hold", {27'd0, out_valid, out_f, out_tag}, held);
            hold_pending = out_valid && !out_ready;
            held = {27'd0, out_valid, out_f, out_tag};
            if (in_valid && in_ready)
                exp_q.push_back('{f: f_ref(in_r, in_k), tag: in_tag});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", 64'(out_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_result", 64'({out_f, out_tag}), 64'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] saved_f;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_k = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_f",     64'(out_f),     64'(0));
        check("rst_out_tag",   64'(out_tag),   64'(0));
        #5 rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Known vector followed back-to-back by the all-zero operation.
        out_ready = 1'b1;
        in_valid = 1'b1; in_r = 32'hF0AAF0AA; in_k = 48'h1B02EFFC7072; in_tag = 4'd1;
        step();
        check("kv_x1",        64'(dut.x1),   64'(48'h6117BA866527));
        check("kv_lat1_valid", 64'(out_valid), 64'(0));
        in_r = '0; in_k = '0; in_tag = 4'd2;
        step();
        in_valid = 1'b0;
        check("kv_valid", 64'(out_valid), 64'(1));
        check("kv_f",     64'(out_f),     64'(32'h234AA9BB));
        check("kv_tag",   64'(out_tag),   64'(1));
        step();
        check("b2b_valid", 64'(out_valid), 64'(1));
        check("b2b_f",     64'(out_f),     64'(f_ref(32'h0, 48'h0)));
        check("b2b_tag",   64'(out_tag),   64'(2));
        step();
        check("b2b_empty", 64'(out_valid), 64'(0));

        // Backpressure: two accepts fill the pipe, the third waits.
        out_ready = 1'b0;
        in_valid = 1'b1; in_r = $urandom; in_k = {16'($urandom), $urandom}; in_tag = 4'd3;
        step();
        check("bp_ready1", 64'(in_ready), 64'(1));
        in_r = $urandom; in_k = {16'($urandom), $urandom}; in_tag = 4'd4;
        step();
        check("bp_ready2", 64'(in_ready), 64'(0));
        check("bp_tag3",   64'(out_tag),  64'(3));
        saved_f = out_f;
        in_r = $urandom; in_k = {16'($urandom), $urandom}; in_tag = 4'd5;
        step();
        check("bp_ready3", 64'(in_ready), 64'(0));
        check("bp_hold_f", 64'(out_f),    64'(saved_f));
        check("bp_hold_t", 64'(out_tag),  64'(3));

        // Full pipe, simultaneous pop and push.
        out_ready = 1'b1;
        #1;
        check("sim_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("sim_full",  64'(in_ready), 64'(0));
        check("sim_tag4",  64'(out_tag),  64'(4));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_tag5", 64'(out_tag), 64'(5));
        step();
        out_ready = 1'b1;
        step();
        check("drain_done", 64'(out_valid), 64'(0));

        // Reset in the middle of a stall with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_r = $urandom; in_k = {16'($urandom), $urandom}; in_tag = 4'd6;
        step();
        in_tag = 4'd7;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_f",     64'(out_f),     64'(0));
        check("mid_rst_ready", 64'(in_ready),  64'(1));
        exp_q.delete();
        #3 rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(in_ready),  64'(1));
        check("post_rst_valid", 64'(out_valid), 64'(0));

        // Random regression with random backpressure.
        for (int c = 0; c < 12000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_r      = $urandom;
            in_k      = {16'($urandom), $urandom};
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("final_drain_q",     64'(exp_q.size()), 64'(0));
        check("final_drain_valid", 64'(out_valid),    64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
